reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file.sv | 45 ++++
 tb/tb_reg_file.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, reused by decode, writeback and the
// register file itself.
package reg_file_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Eight-entry general-purpose register file: two combinational read ports and
// one synchronous write port with synchronous active-low clear. No zero register.
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  import reg_file_pkg::*;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_r;

  // Read multiplexer shared by both ports; no write bypass, so reads see stored state only.
  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
    input logic [ADDR_WIDTH-1:0]            addr
  );
    read_mux = regs[addr];
  endfunction

  // Storage update: clear has priority over a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_r <= '0;
    end else if (write_en) begin
      regs_r[write_addr] <= write_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  assign read_data_1 = read_mux(regs_r, read_addr_1);
  assign read_data_2 = read_mux(regs_r, read_addr_2);

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, fill/readback, write
// disable, no-bypass timing, reset priority, dual-port and back-to-back writes.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        write_en;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [2:0]  read_addr_1;
  logic [2:0]  read_addr_2;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;

  int vectors;
  int miscompares;

  reg_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_1 (read_addr_1),
    .read_addr_2 (read_addr_2),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then step off it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    tick();
    write_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    // Preload every entry with a nonzero value first.
    for (int i = 0; i < 8; i++) begin
      write_reg(3'(i), 16'(16'h1111 * (i + 1)));
    end
    read_addr_1 = 3'd7;
    #1;
    vectors++;
    if (read_data_1 !== 16'h8888) begin
      miscompares++;
      $display("FAIL preload reg7: got %h expected %h", read_data_1, 16'h8888);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      read_addr_1 = 3'(i);
      read_addr_2 = 3'(i);
      #1;
      vectors++;
      if (read_data_1 !== exp || read_data_2 !== exp) begin
        miscompares++;
        $display("FAIL reset addr %0d: got %h/%h expected %h", i, read_data_1, read_data_2, exp);
      end
    end
  endtask

  task automatic test_fill_readback();
    for (int i = 0; i < 8; i++) begin
      write_reg(3'(i), 16'(7 - i));
    end
    for (int i = 0; i < 8; i++) begin
      read_addr_1 = 3'(i);
      read_addr_2 = 3'(7 - i);
      #1;
      vectors++;
      if (read_data_1 !== 16'(7 - i) || read_data_2 !== 16'(i)) begin
        miscompares++;
        $display("FAIL fill i=%0d: got %h/%h expected %h/%h", i, read_data_1, read_data_2,
                 16'(7 - i), 16'(i));
      end
    end
    read_addr_1 = 3'd0;
    #1;
    vectors++;
    if (read_data_1 !== 16'd7) begin
      miscompares++;
      $display("FAIL addr0 ordinary: got %h expected %h", read_data_1, 16'd7);
    end
  endtask

  task automatic test_write_disable();
    write_en   = 1'b0;
    write_addr = 3'd3;
    write_data = 16'hFFFF;
    repeat (4) tick();
    read_addr_2 = 3'd3;
    #1;
    vectors++;
    if (read_data_2 !== 16'd4) begin
      miscompares++;
      $display("FAIL write disable reg3: got %h expected %h", read_data_2, 16'd4);
    end
  endtask

  task automatic test_no_bypass();
    read_addr_1 = 3'd5;
    write_en    = 1'b1;
    write_addr  = 3'd5;
    write_data  = 16'hA5A5;
    #1;
    vectors++;
    if (read_data_1 !== 16'd2) begin
      miscompares++;
      $display("FAIL no bypass before edge: got %h expected %h", read_data_1, 16'd2);
    end
    tick();
    write_en = 1'b0;
    vectors++;
    if (read_data_1 !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL no bypass after edge: got %h expected %h", read_data_1, 16'hA5A5);
    end
  endtask

  task automatic test_reset_priority();
    rst_n      = 1'b0;
    write_en   = 1'b1;
    write_addr = 3'd4;
    write_data = 16'h1234;
    tick();
    rst_n    = 1'b1;
    write_en = 1'b0;
    read_addr_1 = 3'd4;
    read_addr_2 = 3'd5;
    #1;
    vectors++;
    if (read_data_1 !== 16'h0000 || read_data_2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset priority: got %h/%h expected %h/%h", read_data_1, read_data_2,
               16'h0000, 16'h0000);
    end
    // Writes resume on the first edge with reset released.
    write_reg(3'd4, 16'h1234);
    vectors++;
    if (read_data_1 !== 16'h1234) begin
      miscompares++;
      $display("FAIL write after reset: got %h expected %h", read_data_1, 16'h1234);
    end
  endtask

  task automatic test_dual_port();
    read_addr_1 = 3'd6;
    read_addr_2 = 3'd6;
    write_reg(3'd6, 16'h00C3);
    vectors++;
    if (read_data_1 !== 16'h00C3 || read_data_2 !== 16'h00C3) begin
      miscompares++;
      $display("FAIL dual port 00C3: got %h/%h expected %h", read_data_1, read_data_2, 16'h00C3);
    end
    write_reg(3'd6, 16'hFFFF);
    vectors++;
    if (read_data_1 !== 16'hFFFF || read_data_2 !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL dual port FFFF: got %h/%h expected %h", read_data_1, read_data_2, 16'hFFFF);
    end
  endtask

  task automatic test_back_to_back();
    read_addr_1 = 3'd2;
    read_addr_2 = 3'd1;
    write_en    = 1'b1;
    write_addr  = 3'd2;
    write_data  = 16'h0101;
    tick();
    write_data  = 16'h0202;
    tick();
    write_en = 1'b0;
    vectors++;
    if (read_data_1 !== 16'h0202 || read_data_2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL back to back: got %h/%h expected %h/%h", read_data_1, read_data_2,
               16'h0202, 16'h0000);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    write_en    = 1'b0;
    write_addr  = 3'd0;
    write_data  = 16'h0000;
    read_addr_1 = 3'd0;
    read_addr_2 = 3'd0;
    tick();
    rst_n = 1'b1;
    test_reset();
    test_fill_readback();
    test_write_disable();
    test_no_bypass();
    test_reset_priority();
    test_dual_port();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file
